inst_writer: RTL and testbench

INST_WRITER -- requirements
Module: inst_writer

---
 rtl/inst_writer.sv | 156 +++++++++++++++
 tb/tb_inst_writer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_writer.sv
// Encodes instruction requests into 32-bit words and streams them into instruction memory from address 0.
// One output stage register gives 1-cycle latency; a stalled write holds mem_we/mem_addr/mem_wdata and blocks in_ready.
module inst_writer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_opcode,
  input  logic              in_s,
  input  logic              in_imm_en,
  input  logic              in_load,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic [23:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  state_t            state;
  state_t            state_nxt;
  logic              stage_valid;
  logic [31:0]       stage_data;
  logic [ADDR_W-1:0] addr;
  logic              full_q;
  logic              err_q;
  logic              last_seen;

  logic              accept;
  logic              xfer;
  logic              at_top;
  logic              restart;
  logic              is_rsvd;
  logic              block_new;
  logic [11:0]       op2;
  logic [31:0]       enc;

  assign accept  = in_valid && in_ready;
  assign xfer    = stage_valid && mem_ready;
  assign at_top  = (addr == TOP_ADDR);
  assign restart = start && (state != RUN);
  assign is_rsvd = (in_type == 2'd3);

  // Once the last request or the top-address word is in flight, nothing more may enter.
  assign block_new = last_seen || (stage_valid && at_top);

  // Instruction encoder
  assign op2 = in_imm_en ? in_imm[11:0] : {8'h00, in_rm};

  always_comb begin
    enc = 32'h0;
    case (in_type)
      2'd0:    enc = {in_cond, 2'b00, in_imm_en, in_opcode, in_s, in_rn, in_rd, op2};
      2'd1:    enc = {in_cond, 2'b01, ~in_imm_en, 4'b1100, in_load, in_rn, in_rd, op2};
      2'd2:    enc = {in_cond, 3'b101, in_s, in_imm};
      default: enc = 32'h0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // A reserved last request leaves the stage empty, so it ends the session on its own.
        if ((xfer && (last_seen || at_top)) || (last_seen && !stage_valid))
          state_nxt = HALT;
      end
      HALT: begin
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state == RUN) && (!stage_valid || mem_ready) && !block_new;
    done     = (state == HALT);
    busy     = (state == RUN) || stage_valid;
  end

  // Session bookkeeping: address, sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      last_seen <= 1'b0;
    end else if (restart) begin
      addr      <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      if (xfer) begin
        if (at_top) full_q <= 1'b1;
        else        addr   <= addr + 1'b1;
      end
      if (accept && in_last) last_seen <= 1'b1;
      if (accept && is_rsvd) err_q     <= 1'b1;
    end
  end

  // Output stage; a load in the same cycle as a transfer simply replaces the departing word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_data  <= 32'h0;
    end else if (accept && !is_rsvd) begin
      stage_valid <= 1'b1;
      stage_data  <= enc;
    end else if (xfer) begin
      stage_valid <= 1'b0;
    end
  end

  assign mem_we    = stage_valid;
  assign mem_addr  = addr;
  assign mem_wdata = stage_data;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inst_writer.sv
// Directed bench for inst_writer: encoding table, stall hold, full stop, reserved drop, async reset abort.
module tb_inst_writer;

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic        imm_en;
    logic        load;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [23:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, start2, in_valid, in_valid2;
  logic [1:0]  in_type;
  logic [3:0]  in_cond, in_opcode, in_rn, in_rd, in_rm;
  logic        in_s, in_imm_en, in_load, in_last, mem_ready;
  logic [23:0] in_imm;

  logic        in_ready, mem_we, busy, done, full, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        in_ready2, mem_we2, busy2, done2, full2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;

  int checks = 0;
  int errors = 0;

  logic [39:0] wlog[$];
  logic [39:0] wlog2[$];

  vec_t vecs[6];

  always #5 clk = ~clk;

  inst_writer #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_cond(in_cond), .in_opcode(in_opcode), .in_s(in_s),
    .in_imm_en(in_imm_en), .in_load(in_load), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .full(full), .err(err)
  );

  inst_writer #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_type(in_type), .in_cond(in_cond), .in_opcode(in_opcode), .in_s(in_s),
    .in_imm_en(in_imm_en), .in_load(in_load), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we2), .mem_ready(mem_ready),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2), .done(done2), .full(full2), .err(err2)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write logger and hold-while-stalled checker, sampled away from the active edge
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr  = '0;
  logic [31:0] prev_data  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_we", 40'(mem_we), 40'd1);
        check("stall_addr", 40'(mem_addr), 40'(prev_addr));
        check("stall_data", 40'(mem_wdata), 40'(prev_data));
      end
      if (mem_we && mem_ready) wlog.push_back({mem_addr, mem_wdata});
      if (mem_we2 && mem_ready) wlog2.push_back({6'd0, mem_addr2, mem_wdata2});
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_req(input vec_t v);
    in_type   = v.typ;
    in_cond   = v.cond;
    in_opcode = v.opcode;
    in_s      = v.s;
    in_imm_en = v.imm_en;
    in_load   = v.load;
    in_rn     = v.rn;
    in_rd     = v.rd;
    in_rm     = v.rm;
    in_imm    = v.imm;
  endtask

  // Hold the request until the selected DUT accepts it or the budget runs out.
  task automatic offer(input int which, input int budget, output bit acc);
    logic rdy;
    acc = 1'b0;
    if (which == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      rdy = (which == 0) ? in_ready : in_ready2;
      tick();
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t rsv;
    vec_t bv;
    bit   acc;
    int   n;

    vecs[0] = '{typ:2'd0, cond:4'hE, opcode:4'h4, s:1'b0, imm_en:1'b0, load:1'b0,
                rn:4'd2, rd:4'd1, rm:4'd3, imm:24'hFFF123, exp:32'hE0821003};
    vecs[1] = '{typ:2'd1, cond:4'hE, opcode:4'h0, s:1'b0, imm_en:1'b1, load:1'b1,
                rn:4'd1, rd:4'd0, rm:4'd9, imm:24'hABC004, exp:32'hE5910004};
    vecs[2] = '{typ:2'd2, cond:4'h0, opcode:4'h0, s:1'b1, imm_en:1'b0, load:1'b0,
                rn:4'd0, rd:4'd0, rm:4'd0, imm:24'h000010, exp:32'h0B000010};
    vecs[3] = '{typ:2'd1, cond:4'hE, opcode:4'h0, s:1'b0, imm_en:1'b0, load:1'b0,
                rn:4'd3, rd:4'd2, rm:4'd4, imm:24'h000FFF, exp:32'hE7832004};
    vecs[4] = '{typ:2'd0, cond:4'h1, opcode:4'hD, s:1'b1, imm_en:1'b1, load:1'b0,
                rn:4'd0, rd:4'd5, rm:4'd7, imm:24'h0000FF, exp:32'h13B050FF};
    vecs[5] = '{typ:2'd2, cond:4'hA, opcode:4'h0, s:1'b0, imm_en:1'b0, load:1'b0,
                rn:4'd0, rd:4'd0, rm:4'd0, imm:24'hABCDEF, exp:32'hAAABCDEF};
    rsv = '{typ:2'd3, cond:4'hF, opcode:4'hF, s:1'b1, imm_en:1'b1, load:1'b1,
            rn:4'hF, rd:4'hF, rm:4'hF, imm:24'hFFFFFF, exp:32'h0};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_last = 1'b0; mem_ready = 1'b1;
    set_req(vecs[0]);

    // Reset state
    #2;
    check("rst_we", 40'(mem_we), 40'd0);
    check("rst_addr", 40'(mem_addr), 40'd0);
    check("rst_wdata", 40'(mem_wdata), 40'd0);
    check("rst_flags", 40'({in_ready, busy, done, full, err}), 40'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Encoding table: one single-word session per vector
    for (int i = 0; i < 6; i++) begin
      wlog.delete();
      pulse_start();
      set_req(vecs[i]);
      in_last = 1'b1;
      offer(0, 5, acc);
      in_last = 1'b0;
      check($sformatf("vec%0d_accept", i), 40'(acc), 40'd1);
      @(negedge clk);
      check($sformatf("vec%0d_we", i), 40'(mem_we), 40'd1);
      check($sformatf("vec%0d_addr", i), 40'(mem_addr), 40'd0);
      check($sformatf("vec%0d_wdata", i), 40'(mem_wdata), 40'(vecs[i].exp));
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_done", i), 40'({done, mem_we, in_ready, busy}), 40'b1000);
      tick();
    end

    // Three words, 2-cycle stall on the second
    wlog.delete();
    pulse_start();
    set_req(vecs[0]);
    offer(0, 5, acc);
    check("s3_acc_a", 40'(acc), 40'd1);
    set_req(vecs[1]);
    in_valid = 1'b1;
    @(negedge clk);
    check("s3_a_out", 40'({mem_we, mem_addr, mem_wdata}), 40'({1'b1, 8'd0, vecs[0].exp}));
    check("s3_rdy_b", 40'(in_ready), 40'd1);
    tick();
    set_req(vecs[2]);
    in_last = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("s3_b_out", 40'({mem_we, mem_addr, mem_wdata}), 40'({1'b1, 8'd1, vecs[1].exp}));
    check("s3_stall_rdy", 40'(in_ready), 40'd0);
    tick();
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    check("s3_rdy_c", 40'(in_ready), 40'd1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    check("s3_c_out", 40'({mem_we, mem_addr, mem_wdata}), 40'({1'b1, 8'd2, vecs[2].exp}));
    tick();
    @(negedge clk);
    check("s3_end", 40'({done, in_ready}), 40'b10);
    check("s3_nwr", 40'(wlog.size()), 40'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      check($sformatf("s3_wr%0d", i), wlog[i], {8'(i), vecs[i].exp});
    tick();

    // Reserved between two valid requests, with a start pulse ignored mid-session
    wlog.delete();
    pulse_start();
    set_req(vecs[0]);
    offer(0, 5, acc);
    set_req(rsv);
    start = 1'b1;
    offer(0, 5, acc);
    start = 1'b0;
    check("rsv_acc", 40'(acc), 40'd1);
    set_req(vecs[4]);
    in_last = 1'b1;
    offer(0, 5, acc);
    in_last = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) begin
        n = 1;
        break;
      end
      tick();
    end
    check("rsv_done", 40'(n), 40'd1);
    check("rsv_err", 40'(err), 40'd1);
    check("rsv_nwr", 40'(wlog.size()), 40'd2);
    if (wlog.size() == 2) begin
      check("rsv_wr0", wlog[0], {8'd0, vecs[0].exp});
      check("rsv_wr1", wlog[1], {8'd1, vecs[4].exp});
    end
    tick();
    wlog.delete();
    pulse_start();
    @(negedge clk);
    check("restart_clr", 40'({err, done, full, mem_addr}), 40'd0);
    tick();
    // Reserved request carrying in_last still ends the session
    set_req(rsv);
    in_last = 1'b1;
    offer(0, 5, acc);
    in_last = 1'b0;
    tick();
    @(negedge clk);
    check("rsvlast_end", 40'({done, err, mem_we}), 40'b110);
    check("rsvlast_nwr", 40'(wlog.size()), 40'd0);
    tick();

    // Depth-4 instance: 5 offered, only 4 written
    wlog2.delete();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      bv = vecs[2];
      bv.cond = 4'hE;
      bv.s = 1'b0;
      bv.imm = 24'(i);
      set_req(bv);
      offer(1, 8, acc);
      if (acc) n = n + 1;
    end
    check("full_nacc", 40'(n), 40'd4);
    @(negedge clk);
    check("full_flags", 40'({full2, done2, in_ready2, mem_we2, busy2, err2}), 40'b110000);
    check("full_addr", 40'(mem_addr2), 40'd3);
    check("full_nwr", 40'(wlog2.size()), 40'd4);
    for (int i = 0; i < 4 && i < wlog2.size(); i++)
      check($sformatf("full_wr%0d", i), wlog2[i], {8'(i), 32'hEA000000 | 32'(i)});
    tick();

    // Async reset during a stalled write
    wlog.delete();
    pulse_start();
    set_req(vecs[0]);
    offer(0, 5, acc);
    set_req(vecs[1]);
    offer(0, 5, acc);
    mem_ready = 1'b0;
    @(negedge clk);
    check("ar_pre", 40'({mem_we, mem_addr}), 40'({1'b1, 8'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out", 40'({mem_we, mem_addr, mem_wdata}), 40'd0);
    check("ar_flags", 40'({in_ready, busy, done, full, err}), 40'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("ar_idle", 40'({done, busy, in_ready, mem_we}), 40'd0);
    check("ar_nwr", 40'(wlog.size()), 40'd1);
    if (wlog.size() == 1) check("ar_wr0", wlog[0], {8'd0, vecs[0].exp});
    tick();
    pulse_start();
    set_req(vecs[5]);
    in_last = 1'b1;
    offer(0, 5, acc);
    in_last = 1'b0;
    @(negedge clk);
    check("ar_restart", 40'({mem_we, mem_addr, mem_wdata}), 40'({1'b1, 8'd0, vecs[5].exp}));
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
